traffic_light_controller_n: RTL

Parametrised N-path traffic light controller, the cycle-accurate successor to the fixed three-path sequencer. Phase durations are counted in clock cycles instead of simulation delays. The block adds an all-red clearance interval, demand-based skipping of idle paths, a pause enable and a flashing-yellow night mode. It sits between the intersection sensor/mode logic and the lamp drivers; one instance serves one intersection.

---
 rtl/traffic_light_controller_n_if.sv | 25 ++
 rtl/traffic_light_controller_n.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller_n_if.sv
// Sensor/mode inputs and lamp-driver outputs of one intersection sequencer.
interface traffic_light_controller_n_if #(
    parameter int NUM_PATHS = 3
);
    localparam int P_W = $clog2(NUM_PATHS);

    logic                 enable;
    logic                 flash;
    logic [NUM_PATHS-1:0] demand;
    logic [NUM_PATHS-1:0] red;
    logic [NUM_PATHS-1:0] yellow;
    logic [NUM_PATHS-1:0] green;
    logic [P_W-1:0]       active_path;
    logic [1:0]           phase;

    modport master (
        output enable, flash, demand,
        input  red, yellow, green, active_path, phase
    );

    modport slave (
        input  enable, flash, demand,
        output red, yellow, green, active_path, phase
    );
endinterface

// File: rtl/traffic_light_controller_n.sv
// N-path traffic light sequencer: green/yellow/all-red rotation with demand skipping,
// pause enable and flashing-yellow night mode, all durations counted in clocks.
module traffic_light_controller_n #(
    parameter int NUM_PATHS     = 3,
    parameter int CNT_W         = 8,
    parameter int GREEN_CYCLES  = 10,
    parameter int YELLOW_CYCLES = 4,
    parameter int ALLRED_CYCLES = 1,
    parameter int FLASH_CYCLES  = 8
) (
    input logic                         clk,
    input logic                         reset,
    traffic_light_controller_n_if.slave bus
);
    localparam int               P_W       = $clog2(NUM_PATHS);
    localparam int               PW1       = P_W + 1;
    localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] Y_LOAD    = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] A_LOAD    = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] F_LOAD    = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [P_W-1:0]   LAST_PATH = P_W'(NUM_PATHS - 1);
    localparam logic [PW1-1:0]   N_WIDE    = PW1'(NUM_PATHS);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [P_W-1:0]   p_r;
    logic [P_W-1:0]   p_nxt_s;
    logic [P_W-1:0]   next_path_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt_s;
    logic             blink_r;
    logic             blink_nxt_s;
    logic             expire_s;
    logic             found_s;
    logic [PW1-1:0]   cand_s;

    function automatic logic [3*NUM_PATHS-1:0] lamps_f(
        input state_t         st,
        input logic [P_W-1:0] p,
        input logic           blink
    );
        logic [NUM_PATHS-1:0] oh;
        logic [NUM_PATHS-1:0] zero;
        logic [NUM_PATHS-1:0] ones;
        oh   = {{(NUM_PATHS-1){1'b0}}, 1'b1} << p;
        zero = {NUM_PATHS{1'b0}};
        ones = {NUM_PATHS{1'b1}};
        // Packed as {red, yellow, green}.
        case (st)
            ST_GREEN:  lamps_f = {~oh, zero, oh};
            ST_YELLOW: lamps_f = {~oh, oh, zero};
            ST_ALLRED: lamps_f = {ones, zero, zero};
            ST_FLASH:  lamps_f = {zero, {NUM_PATHS{blink}}, zero};
            default:   lamps_f = {ones, zero, zero};
        endcase
    endfunction

    // Cyclic search for the first demanding path after p, p itself last.
    always_comb begin
        next_path_s = (p_r == LAST_PATH) ? {P_W{1'b0}} : p_r + P_W'(1);
        found_s     = 1'b0;
        cand_s      = {PW1{1'b0}};
        for (int k = 1; k <= NUM_PATHS; k++) begin
            cand_s      = {1'b0, p_r} + PW1'(k);
            cand_s      = (cand_s >= N_WIDE) ? cand_s - N_WIDE : cand_s;
            next_path_s = (!found_s && bus.demand[cand_s[P_W-1:0]]) ? cand_s[P_W-1:0] : next_path_s;
            found_s     = found_s | bus.demand[cand_s[P_W-1:0]];
        end
    end

    // Next-state, path, timer and blink selection; flash overrides enable.
    always_comb begin
        state_nxt_s = state_r;
        p_nxt_s     = p_r;
        timer_nxt_s = timer_r;
        blink_nxt_s = blink_r;
        expire_s    = (timer_r == {CNT_W{1'b0}});
        if (bus.flash) begin
            if (state_r != ST_FLASH) begin
                state_nxt_s = ST_FLASH;
                timer_nxt_s = F_LOAD;
                blink_nxt_s = 1'b1;
            end else if (bus.enable && expire_s) begin
                timer_nxt_s = F_LOAD;
                blink_nxt_s = ~blink_r;
            end else if (bus.enable) begin
                timer_nxt_s = timer_r - CNT_W'(1);
            end else begin
                timer_nxt_s = timer_r;
            end
        end else if (state_r == ST_FLASH) begin
            // Leaving night mode from the last path makes the search start at path 0.
            state_nxt_s = ST_ALLRED;
            p_nxt_s     = LAST_PATH;
            timer_nxt_s = A_LOAD;
        end else if (bus.enable && !expire_s) begin
            timer_nxt_s = timer_r - CNT_W'(1);
        end else if (bus.enable) begin
            case (state_r)
                ST_GREEN: begin
                    state_nxt_s = ST_YELLOW;
                    timer_nxt_s = Y_LOAD;
                end
                ST_YELLOW: begin
                    state_nxt_s = ST_ALLRED;
                    timer_nxt_s = A_LOAD;
                end
                ST_ALLRED: begin
                    state_nxt_s = ST_GREEN;
                    p_nxt_s     = next_path_s;
                    timer_nxt_s = G_LOAD;
                end
                default: begin
                    state_nxt_s = ST_ALLRED;
                    timer_nxt_s = A_LOAD;
                end
            endcase
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // State registers; lamps are registered from the same next-state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_GREEN;
            p_r             <= {P_W{1'b0}};
            timer_r         <= G_LOAD;
            blink_r         <= 1'b0;
            bus.red         <= {{(NUM_PATHS-1){1'b1}}, 1'b0};
            bus.yellow      <= {NUM_PATHS{1'b0}};
            bus.green       <= {{(NUM_PATHS-1){1'b0}}, 1'b1};
            bus.active_path <= {P_W{1'b0}};
            bus.phase       <= 2'd0;
        end else begin
            state_r                          <= state_nxt_s;
            p_r                              <= p_nxt_s;
            timer_r                          <= timer_nxt_s;
            blink_r                          <= blink_nxt_s;
            {bus.red, bus.yellow, bus.green} <= lamps_f(state_nxt_s, p_nxt_s, blink_nxt_s);
            bus.active_path                  <= p_nxt_s;
            bus.phase                        <= state_nxt_s;
        end
    end
endmodule
